// File: rtl/iram_pkg.sv
// rtl/iram_pkg.sv - shared constants, state enum and helpers for the instruction refill responder
package iram_pkg;

  localparam int PC_SIZE_DEF    = 32;
  localparam int WORD_W_DEF     = 32;
  localparam int LINE_WORDS_DEF = 4;

  function automatic int line_ofs_w(input int line_words);
    return $clog2(line_words);
  endfunction

  localparam int LINE_OFS_W = line_ofs_w(LINE_WORDS_DEF);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DRAIN,
    DONE
  } iram_state_t;

endpackage

// File: rtl/iram_controller_if.sv
// rtl/iram_controller_if.sv - core refill port plus single-outstanding instruction memory port
interface iram_controller_if
  import iram_pkg::*;
#(
  parameter int PC_SIZE = PC_SIZE_DEF,
  parameter int WORD_W  = WORD_W_DEF
);
  logic [PC_SIZE-1:0] iram_address;
  logic               i_miss;
  logic [WORD_W-1:0]  imem_word;
  logic               word_ready;
  logic               mem_req;
  logic [PC_SIZE-1:0] mem_addr;
  logic               mem_rvalid;
  logic [WORD_W-1:0]  mem_rdata;
  logic               busy;

  modport slave (
    input  iram_address, i_miss, mem_rvalid, mem_rdata,
    output imem_word, word_ready, mem_req, mem_addr, busy
  );

  modport master (
    output iram_address, i_miss, mem_rvalid, mem_rdata,
    input  imem_word, word_ready, mem_req, mem_addr, busy
  );
endinterface

// File: rtl/iram_controller.sv
// rtl/iram_controller.sv - critical-word-first cache line refill with wrap-around, one read in flight
module iram_controller
  import iram_pkg::*;
#(
  parameter int PC_SIZE    = PC_SIZE_DEF,
  parameter int WORD_W     = WORD_W_DEF,
  parameter int LINE_WORDS = LINE_WORDS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  iram_controller_if.slave bus
);

  localparam int OFS_W = line_ofs_w(LINE_WORDS);
  localparam int OFS   = OFS_W + 2;
  localparam logic [PC_SIZE-1:0] LINE_MASK = ~{{(PC_SIZE-OFS){1'b0}}, {OFS{1'b1}}};
  localparam logic [OFS_W:0]     CNT_FULL  = (OFS_W+1)'(LINE_WORDS);

  iram_state_t        state;
  logic [PC_SIZE-1:0] base_q;
  logic [OFS_W-1:0]   start_q;
  logic [OFS_W-1:0]   next_ofs;
  logic [OFS_W:0]     count_q;
  logic [OFS_W:0]     cnt_inc;
  logic               outstanding;
  logic               rvalid_ok;
  logic [WORD_W-1:0]  rdata;

  assign rdata = bus.mem_rdata;

  // Offset arithmetic is done in OFS_W bits so it wraps inside the line and never carries into base.
  always_comb begin
    cnt_inc   = count_q + (OFS_W+1)'(1);
    next_ofs  = start_q + cnt_inc[OFS_W-1:0];
    rvalid_ok = bus.mem_rvalid && outstanding;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      base_q         <= '0;
      start_q        <= '0;
      count_q        <= '0;
      outstanding    <= 1'b0;
      bus.imem_word  <= '0;
      bus.word_ready <= 1'b0;
      bus.mem_req    <= 1'b0;
      bus.mem_addr   <= '0;
      bus.busy       <= 1'b0;
    end else begin
      bus.word_ready <= 1'b0;
      bus.mem_req    <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_miss) begin
            base_q      <= bus.iram_address & LINE_MASK;
            start_q     <= bus.iram_address[OFS-1:2];
            count_q     <= '0;
            bus.mem_req <= 1'b1;
            bus.mem_addr <= {bus.iram_address[PC_SIZE-1:2], 2'b00};
            outstanding <= 1'b1;
            bus.busy    <= 1'b1;
            state       <= REQ;
          end
        end
        // mem_req is visible during REQ, so the read is already in flight here.
        REQ: begin
          if (!bus.i_miss) begin
            state    <= outstanding ? DRAIN : IDLE;
            bus.busy <= outstanding;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (!bus.i_miss) begin
            if (rvalid_ok || !outstanding) begin
              outstanding <= 1'b0;
              state       <= IDLE;
              bus.busy    <= 1'b0;
            end else begin
              state <= DRAIN;
            end
          end else if (rvalid_ok) begin
            bus.imem_word  <= rdata;
            bus.word_ready <= 1'b1;
            count_q        <= cnt_inc;
            if (cnt_inc == CNT_FULL) begin
              outstanding <= 1'b0;
              state       <= DONE;
            end else begin
              bus.mem_req  <= 1'b1;
              bus.mem_addr <= base_q | {{(PC_SIZE-OFS){1'b0}}, next_ofs, 2'b00};
              outstanding  <= 1'b1;
              state        <= REQ;
            end
          end
        end
        DRAIN: begin
          if (rvalid_ok || !outstanding) begin
            outstanding <= 1'b0;
            state       <= IDLE;
            bus.busy    <= 1'b0;
          end
        end
        DONE: begin
          if (!bus.i_miss) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end
        default: begin
          outstanding <= 1'b0;
          state       <= IDLE;
          bus.busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iram_controller.sv
// tb/tb_iram_controller.sv - directed self-checking bench for the instruction refill responder
module tb_iram_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   lat      = 2;
  bit   stray    = 1'b0;
  int   consec   = 0;
  bit   prev_wr  = 1'b0;

  logic [31:0] req_addr[$];
  int          req_cyc[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];

  iram_controller_if #(.PC_SIZE(32), .WORD_W(32)) bus ();

  iram_controller #(.PC_SIZE(32), .WORD_W(32), .LINE_WORDS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory returns D000_0000|addr exactly lat cycles after the request was seen.
  initial begin
    int          pend;
    logic [31:0] paddr;
    pend = -1;
    paddr = '0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.mem_rvalid = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = 32'hD000_0000 | paddr;
          pend = -1;
        end
      end
      if (stray) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hDEAD_BEEF;
        stray = 1'b0;
      end
      if (bus.mem_req === 1'b1) begin
        paddr = bus.mem_addr;
        pend  = lat;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #2;
    if (bus.mem_req === 1'b1) begin
      req_addr.push_back(bus.mem_addr);
      req_cyc.push_back(cyc);
    end
    if (bus.word_ready === 1'b1) begin
      wr_data.push_back(bus.imem_word);
      wr_cyc.push_back(cyc);
      if (prev_wr) consec++;
    end
    prev_wr = (bus.word_ready === 1'b1);
  endtask

  task automatic clear_log();
    req_addr.delete();
    req_cyc.delete();
    wr_data.delete();
    wr_cyc.delete();
  endtask

  task automatic test_reset();
    bus.i_miss = 1'b0;
    bus.iram_address = '0;
    rst = 1'b1;
    step();
    step();
    checks++; if (bus.word_ready !== 1'b0) begin failures++; $display("FAIL reset_word_ready got=%b exp=0", bus.word_ready); end
    checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%b exp=0", bus.mem_req); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.mem_addr !== 32'h0) begin failures++; $display("FAIL reset_mem_addr got=%h exp=0", bus.mem_addr); end
    checks++; if (bus.imem_word !== 32'h0) begin failures++; $display("FAIL reset_imem_word got=%h exp=0", bus.imem_word); end
    rst = 1'b0;
    step();
    step();
    checks++; if (bus.busy !== 1'b0 || req_addr.size() != 0) begin failures++; $display("FAIL idle_after_reset busy=%b reqs=%0d exp busy=0 reqs=0", bus.busy, req_addr.size()); end
  endtask

  task automatic test_basic();
    logic [31:0] exp_a[4];
    logic [31:0] exp_d[4];
    int t0;
    exp_a = '{32'h108, 32'h10C, 32'h100, 32'h104};
    exp_d = '{32'hD000_0108, 32'hD000_010C, 32'hD000_0100, 32'hD000_0104};
    lat = 2;
    clear_log();
    bus.iram_address = 32'h0000_0108;
    bus.i_miss = 1'b1;
    t0 = cyc;
    step();
    bus.iram_address = 32'hFFFF_FFF0;
    for (int i = 0; i < 13; i++) step();
    checks++; if (req_addr.size() != 4) begin failures++; $display("FAIL basic_req_count got=%0d exp=4", req_addr.size()); end
    checks++; if (wr_data.size() != 4) begin failures++; $display("FAIL basic_word_count got=%0d exp=4", wr_data.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < req_addr.size()) begin
        checks++; if (req_addr[i] !== exp_a[i]) begin failures++; $display("FAIL basic_addr[%0d] got=%h exp=%h", i, req_addr[i], exp_a[i]); end
        checks++; if (req_cyc[i] - t0 != 1 + 3*i) begin failures++; $display("FAIL basic_req_cycle[%0d] got=%0d exp=%0d", i, req_cyc[i] - t0, 1 + 3*i); end
      end
      if (i < wr_data.size()) begin
        checks++; if (wr_data[i] !== exp_d[i]) begin failures++; $display("FAIL basic_data[%0d] got=%h exp=%h", i, wr_data[i], exp_d[i]); end
        checks++; if (wr_cyc[i] - t0 != 4 + 3*i) begin failures++; $display("FAIL basic_ready_cycle[%0d] got=%0d exp=%0d", i, wr_cyc[i] - t0, 4 + 3*i); end
      end
    end
    for (int i = 0; i < 3; i++) step();
    checks++; if (bus.busy !== 1'b1 || req_addr.size() != 4) begin failures++; $display("FAIL basic_done_hold busy=%b reqs=%0d exp busy=1 reqs=4", bus.busy, req_addr.size()); end
    bus.i_miss = 1'b0;
    step();
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL basic_done_exit busy=%b exp=0", bus.busy); end
  endtask

  task automatic test_aligned();
    logic [31:0] exp_a[4];
    int t0;
    exp_a = '{32'h200, 32'h204, 32'h208, 32'h20C};
    lat = 1;
    clear_log();
    bus.iram_address = 32'h0000_0200;
    bus.i_miss = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 11; i++) step();
    checks++; if (req_addr.size() != 4 || wr_data.size() != 4) begin failures++; $display("FAIL aligned_counts reqs=%0d words=%0d exp 4/4", req_addr.size(), wr_data.size()); end
    for (int i = 0; i < req_addr.size() && i < 4; i++) begin
      checks++; if (req_addr[i] !== exp_a[i]) begin failures++; $display("FAIL aligned_addr[%0d] got=%h exp=%h", i, req_addr[i], exp_a[i]); end
    end
    if (wr_cyc.size() == 4) begin
      checks++; if (wr_cyc[3] - t0 != 9) begin failures++; $display("FAIL aligned_line_latency got=%0d exp=9", wr_cyc[3] - t0); end
      checks++; if (wr_data[2] !== 32'hD000_0208) begin failures++; $display("FAIL aligned_data2 got=%h exp=D0000208", wr_data[2]); end
    end
    bus.i_miss = 1'b0;
    step();
  endtask

  task automatic test_abort();
    logic [31:0] exp_a[4];
    bit found;
    int t0;
    exp_a = '{32'h300, 32'h304, 32'h308, 32'h30C};
    lat = 2;
    clear_log();
    bus.iram_address = 32'h0000_0184;
    bus.i_miss = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (req_addr.size() == 2) found = 1'b1;
    end
    checks++; if (!found) begin failures++; $display("FAIL abort_second_req not seen within 20 cycles reqs=%0d exp=2", req_addr.size()); end
    step();
    bus.i_miss = 1'b0;
    step();
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL abort_drain_busy got=%b exp=1", bus.busy); end
    step();
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL abort_idle_busy got=%b exp=0", bus.busy); end
    for (int i = 0; i < 4; i++) step();
    checks++; if (wr_data.size() != 1 || req_addr.size() != 2) begin failures++; $display("FAIL abort_no_more words=%0d reqs=%0d exp 1/2", wr_data.size(), req_addr.size()); end
    lat = 1;
    clear_log();
    bus.iram_address = 32'h0000_0300;
    bus.i_miss = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 10; i++) step();
    checks++; if (req_addr.size() != 4 || wr_data.size() != 4) begin failures++; $display("FAIL abort_restart_counts reqs=%0d words=%0d exp 4/4", req_addr.size(), wr_data.size()); end
    for (int i = 0; i < req_addr.size() && i < 4; i++) begin
      checks++; if (req_addr[i] !== exp_a[i]) begin failures++; $display("FAIL abort_restart_addr[%0d] got=%h exp=%h", i, req_addr[i], exp_a[i]); end
    end
    if (req_cyc.size() > 0) begin
      checks++; if (req_cyc[0] - t0 != 1) begin failures++; $display("FAIL abort_restart_first_req got=%0d exp=1", req_cyc[0] - t0); end
    end
    if (wr_data.size() == 4) begin
      checks++; if (wr_data[3] !== 32'hD000_030C) begin failures++; $display("FAIL abort_restart_data3 got=%h exp=D000030C", wr_data[3]); end
    end
    bus.i_miss = 1'b0;
    step();
  endtask

  task automatic test_simultaneous();
    lat = 2;
    clear_log();
    bus.iram_address = 32'h0000_0500;
    bus.i_miss = 1'b1;
    step();
    step();
    bus.i_miss = 1'b0;
    step();
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL simul_wait_busy got=%b exp=1", bus.busy); end
    step();
    checks++; if (bus.busy !== 1'b0 || bus.word_ready !== 1'b0) begin failures++; $display("FAIL simul_drop busy=%b word_ready=%b exp 0/0", bus.busy, bus.word_ready); end
    step();
    step();
    checks++; if (wr_data.size() != 0) begin failures++; $display("FAIL simul_no_word got=%0d exp=0", wr_data.size()); end
    stray = 1'b1;
    for (int i = 0; i < 3; i++) step();
    checks++; if (wr_data.size() != 0 || req_addr.size() != 1 || bus.busy !== 1'b0) begin failures++; $display("FAIL stray_rvalid words=%0d reqs=%0d busy=%b exp 0/1/0", wr_data.size(), req_addr.size(), bus.busy); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp_a[4];
    exp_a = '{32'h010, 32'h014, 32'h018, 32'h01C};
    lat = 3;
    clear_log();
    bus.iram_address = 32'h0000_0020;
    bus.i_miss = 1'b1;
    step();
    step();
    rst = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.mem_req !== 1'b0 || bus.word_ready !== 1'b0) begin failures++; $display("FAIL rstmid_ctrl busy=%b req=%b ready=%b exp 0/0/0", bus.busy, bus.mem_req, bus.word_ready); end
    checks++; if (bus.mem_addr !== 32'h0 || bus.imem_word !== 32'h0) begin failures++; $display("FAIL rstmid_data addr=%h word=%h exp 0/0", bus.mem_addr, bus.imem_word); end
    bus.i_miss = 1'b0;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step();
    checks++; if (wr_data.size() != 0 || bus.busy !== 1'b0) begin failures++; $display("FAIL rstmid_stale words=%0d busy=%b exp 0/0", wr_data.size(), bus.busy); end
    lat = 1;
    clear_log();
    bus.iram_address = 32'h0000_0010;
    bus.i_miss = 1'b1;
    for (int i = 0; i < 10; i++) step();
    checks++; if (req_addr.size() != 4 || wr_data.size() != 4) begin failures++; $display("FAIL rstmid_refill_counts reqs=%0d words=%0d exp 4/4", req_addr.size(), wr_data.size()); end
    for (int i = 0; i < req_addr.size() && i < 4; i++) begin
      checks++; if (req_addr[i] !== exp_a[i]) begin failures++; $display("FAIL rstmid_addr[%0d] got=%h exp=%h", i, req_addr[i], exp_a[i]); end
    end
    if (wr_data.size() == 4) begin
      checks++; if (wr_data[3] !== 32'hD000_001C) begin failures++; $display("FAIL rstmid_data3 got=%h exp=D000001C", wr_data[3]); end
    end
    bus.i_miss = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_a[4];
    int t0;
    exp_a = '{32'h400, 32'h404, 32'h408, 32'h40C};
    lat = 1;
    clear_log();
    bus.iram_address = 32'h0000_0600;
    bus.i_miss = 1'b1;
    for (int i = 0; i < 11; i++) step();
    checks++; if (wr_data.size() != 4) begin failures++; $display("FAIL b2b_first_line words=%0d exp=4", wr_data.size()); end
    bus.iram_address = 32'h0000_0400;
    clear_log();
    for (int i = 0; i < 3; i++) step();
    checks++; if (req_addr.size() != 0 || bus.busy !== 1'b1) begin failures++; $display("FAIL b2b_held_in_done reqs=%0d busy=%b exp 0/1", req_addr.size(), bus.busy); end
    bus.i_miss = 1'b0;
    step();
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL b2b_idle busy=%b exp=0", bus.busy); end
    bus.i_miss = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 10; i++) step();
    checks++; if (req_addr.size() != 4) begin failures++; $display("FAIL b2b_second_reqs got=%0d exp=4", req_addr.size()); end
    for (int i = 0; i < req_addr.size() && i < 4; i++) begin
      checks++; if (req_addr[i] !== exp_a[i]) begin failures++; $display("FAIL b2b_addr[%0d] got=%h exp=%h", i, req_addr[i], exp_a[i]); end
    end
    if (req_cyc.size() > 0) begin
      checks++; if (req_cyc[0] - t0 != 1) begin failures++; $display("FAIL b2b_first_req got=%0d exp=1", req_cyc[0] - t0); end
    end
    bus.i_miss = 1'b0;
    step();
    step();
    checks++; if (consec != 0) begin failures++; $display("FAIL word_ready_consecutive got=%0d exp=0", consec); end
  endtask

  initial begin
    bus.i_miss = 1'b0;
    bus.iram_address = '0;
    test_reset();
    test_basic();
    test_aligned();
    test_abort();
    test_simultaneous();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
